// File: rtl/trng_ehr_rd_ctrl_pkg.sv
// Shared constants and FSM state encoding for the TRNG EHR read controller.
package trng_ehr_rd_ctrl_pkg;

  localparam int EHR_WIDTH_DEF = 192;
  localparam int WORD_W_DEF    = 32;
  localparam int IDX_W_DEF     = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } ehr_state_e;

endpackage

// File: rtl/trng_ehr_word_mux.sv
// Combinational word selector: picks word idx out of the EHR shadow and flags the final word.
module trng_ehr_word_mux
  import trng_ehr_rd_ctrl_pkg::*;
#(
  parameter int EHR_WIDTH = EHR_WIDTH_DEF,
  parameter int WORD_W    = WORD_W_DEF,
  parameter int IDX_W     = IDX_W_DEF
) (
  input  logic [EHR_WIDTH-1:0] shadow,
  input  logic [IDX_W-1:0]     idx,
  output logic [WORD_W-1:0]    word,
  output logic                 last
);

  localparam int NUM_WORDS = EHR_WIDTH / WORD_W;

  logic [WORD_W-1:0] word_arr [NUM_WORDS];

  generate
    for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_split
      assign word_arr[gi] = shadow[gi*WORD_W +: WORD_W];
    end
  endgenerate

  // Out-of-range indices resolve to zero rather than reading past the shadow.
  always_comb begin
    word = '0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      if (idx == IDX_W'(i)) word = word_arr[i];
    end
  end

  assign last = (idx == IDX_W'(NUM_WORDS - 1));

endmodule

// File: rtl/trng_ehr_rd_ctrl.sv
// Snapshots a full EHR and streams it LSW-first over valid/ready, with read strobes back to the TRNG.
// Optional TRNG_EHR_ZEROIZE_EN: wipe each consumed word, and the whole shadow on soft reset.
module trng_ehr_rd_ctrl
  import trng_ehr_rd_ctrl_pkg::*;
#(
  parameter int EHR_WIDTH = EHR_WIDTH_DEF,
  parameter int WORD_W    = WORD_W_DEF,
  parameter int IDX_W     = IDX_W_DEF
) (
  input  logic                 rng_clk,
  input  logic                 rst_n,
  input  logic                 ehr_valid_in,
  input  logic [EHR_WIDTH-1:0] ehr_data,
  input  logic                 rst_trng_logic,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [WORD_W-1:0]    out_data,
  output logic                 out_last,
  output logic                 ehr_word_rd,
  output logic                 ehr_rd_done,
  output logic                 in_mid_rd,
  output logic [IDX_W-1:0]     words_left
);

  localparam int NUM_WORDS = EHR_WIDTH / WORD_W;

  ehr_state_e           state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [IDX_W-1:0]     words_left_q, words_left_d;
  logic [EHR_WIDTH-1:0] shadow_q, shadow_d;
  logic                 in_mid_rd_q, in_mid_rd_d;

  logic [WORD_W-1:0]    mux_word;
  logic                 mux_last;
  logic                 handshake;

  trng_ehr_word_mux #(
    .EHR_WIDTH (EHR_WIDTH),
    .WORD_W    (WORD_W),
    .IDX_W     (IDX_W)
  ) u_word_mux (
    .shadow (shadow_q),
    .idx    (idx_q),
    .word   (mux_word),
    .last   (mux_last)
  );

  // Soft reset wins over a same-cycle handshake, so the word is not counted as consumed.
  assign handshake = (state_q == ST_STREAM) && out_ready && !rst_trng_logic;

  always_ff @(posedge rng_clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      words_left_q <= '0;
      shadow_q     <= '0;
      in_mid_rd_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      words_left_q <= words_left_d;
      shadow_q     <= shadow_d;
      in_mid_rd_q  <= in_mid_rd_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    words_left_d = words_left_q;
    shadow_d     = shadow_q;
    in_mid_rd_d  = in_mid_rd_q;

    if (rst_trng_logic) begin
      state_d      = ST_IDLE;
      idx_d        = '0;
      words_left_d = '0;
      in_mid_rd_d  = 1'b0;
`ifdef TRNG_EHR_ZEROIZE_EN
      shadow_d     = '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ehr_valid_in) begin
            shadow_d     = ehr_data;
            idx_d        = '0;
            words_left_d = IDX_W'(NUM_WORDS);
            state_d      = ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (handshake) begin
            words_left_d = words_left_q - IDX_W'(1);
            in_mid_rd_d  = !mux_last;
`ifdef TRNG_EHR_ZEROIZE_EN
            for (int i = 0; i < NUM_WORDS; i++) begin
              if (idx_q == IDX_W'(i)) shadow_d[i*WORD_W +: WORD_W] = '0;
            end
`endif
            // Index parks at 0 after the final word so IDLE/DONE look like reset.
            if (mux_last) begin
              idx_d   = '0;
              state_d = ST_DONE;
            end else begin
              idx_d   = idx_q + IDX_W'(1);
            end
          end
        end
        ST_DONE: begin
          words_left_d = '0;
          in_mid_rd_d  = 1'b0;
          state_d      = ST_IDLE;
        end
        default: begin
          idx_d        = '0;
          words_left_d = '0;
          in_mid_rd_d  = 1'b0;
          state_d      = ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    out_valid   = (state_q == ST_STREAM);
    out_data    = (state_q == ST_STREAM) ? mux_word : '0;
    out_last    = (state_q == ST_STREAM) && mux_last;
    ehr_word_rd = handshake;
    ehr_rd_done = (state_q == ST_DONE);
    in_mid_rd   = in_mid_rd_q;
    words_left  = words_left_q;
  end

endmodule

// File: tb/tb_trng_ehr_rd_ctrl.sv
// Directed self-checking bench for trng_ehr_rd_ctrl; inputs change and outputs are sampled just after negedge.
module tb_trng_ehr_rd_ctrl;

  logic         rng_clk = 1'b0;
  logic         rst_n;
  logic         ehr_valid_in;
  logic [191:0] ehr_data;
  logic         rst_trng_logic;
  logic         out_ready;
  logic         out_valid;
  logic [31:0]  out_data;
  logic         out_last;
  logic         ehr_word_rd;
  logic         ehr_rd_done;
  logic         in_mid_rd;
  logic [2:0]   words_left;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  logic [191:0] d_inc;
  logic [191:0] d_hund;

  trng_ehr_rd_ctrl dut (
    .rng_clk        (rng_clk),
    .rst_n          (rst_n),
    .ehr_valid_in   (ehr_valid_in),
    .ehr_data       (ehr_data),
    .rst_trng_logic (rst_trng_logic),
    .out_ready      (out_ready),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_last       (out_last),
    .ehr_word_rd    (ehr_word_rd),
    .ehr_rd_done    (ehr_rd_done),
    .in_mid_rd      (in_mid_rd),
    .words_left     (words_left)
  );

  always #5 rng_clk = ~rng_clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic test_reset();
    rst_n = 1'b0; ehr_valid_in = 1'b1; ehr_data = d_inc; rst_trng_logic = 1'b0; out_ready = 1'b1;
    @(negedge rng_clk); #1;
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", out_valid); else pass_cnt++;
    chk_cnt++; if (out_data !== 32'h0) $display("FAIL reset_data got=%h exp=0", out_data); else pass_cnt++;
    chk_cnt++; if (out_last !== 1'b0) $display("FAIL reset_last got=%b exp=0", out_last); else pass_cnt++;
    chk_cnt++; if (ehr_word_rd !== 1'b0) $display("FAIL reset_word_rd got=%b exp=0", ehr_word_rd); else pass_cnt++;
    chk_cnt++; if (ehr_rd_done !== 1'b0) $display("FAIL reset_rd_done got=%b exp=0", ehr_rd_done); else pass_cnt++;
    chk_cnt++; if (in_mid_rd !== 1'b0) $display("FAIL reset_mid got=%b exp=0", in_mid_rd); else pass_cnt++;
    chk_cnt++; if (words_left !== 3'd0) $display("FAIL reset_words_left got=%0d exp=0", words_left); else pass_cnt++;
    $display("reset: outputs checked");
    @(negedge rng_clk); rst_n = 1'b1; ehr_valid_in = 1'b0;
  endtask

  task automatic test_stream();
    int rd_cnt;
    rd_cnt = 0;
    @(negedge rng_clk); ehr_data = d_inc; ehr_valid_in = 1'b1; out_ready = 1'b1; #1;
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL stream_latency got=%b exp=0", out_valid); else pass_cnt++;
    for (int k = 1; k <= 6; k++) begin
      @(negedge rng_clk); ehr_valid_in = 1'b0; #1;
      chk_cnt++; if (out_valid !== 1'b1) $display("FAIL stream_valid k=%0d got=%b exp=1", k, out_valid); else pass_cnt++;
      chk_cnt++; if (out_data !== 32'(k)) $display("FAIL stream_data k=%0d got=%h exp=%h", k, out_data, 32'(k)); else pass_cnt++;
      chk_cnt++; if (out_last !== (k == 6)) $display("FAIL stream_last k=%0d got=%b exp=%b", k, out_last, (k == 6)); else pass_cnt++;
      chk_cnt++; if (words_left !== 3'(7 - k)) $display("FAIL stream_words_left k=%0d got=%0d exp=%0d", k, words_left, 7 - k); else pass_cnt++;
      chk_cnt++; if (in_mid_rd !== (k > 1)) $display("FAIL stream_mid k=%0d got=%b exp=%b", k, in_mid_rd, (k > 1)); else pass_cnt++;
      if (ehr_word_rd === 1'b1) rd_cnt++;
      $display("stream: word %0d data=%h last=%b", k, out_data, out_last);
    end
    @(negedge rng_clk); #1;
    chk_cnt++; if (ehr_rd_done !== 1'b1) $display("FAIL stream_done got=%b exp=1", ehr_rd_done); else pass_cnt++;
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL stream_done_valid got=%b exp=0", out_valid); else pass_cnt++;
    chk_cnt++; if (in_mid_rd !== 1'b0) $display("FAIL stream_done_mid got=%b exp=0", in_mid_rd); else pass_cnt++;
    chk_cnt++; if (words_left !== 3'd0) $display("FAIL stream_done_words_left got=%0d exp=0", words_left); else pass_cnt++;
    chk_cnt++; if (ehr_word_rd !== 1'b0) $display("FAIL stream_done_word_rd got=%b exp=0", ehr_word_rd); else pass_cnt++;
    @(negedge rng_clk); #1;
    chk_cnt++; if (ehr_rd_done !== 1'b0) $display("FAIL stream_done_width got=%b exp=0", ehr_rd_done); else pass_cnt++;
    chk_cnt++; if (rd_cnt !== 6) $display("FAIL stream_rd_count got=%0d exp=6", rd_cnt); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int acc, cyc, rd_cnt;
    acc = 0; cyc = 0; rd_cnt = 0;
    @(negedge rng_clk); ehr_data = d_inc; ehr_valid_in = 1'b1; out_ready = 1'b0;
    while (acc < 6 && cyc < 60) begin
      @(negedge rng_clk); ehr_valid_in = 1'b0; out_ready = (cyc % 3 == 0); #1;
      chk_cnt++; if (out_valid !== 1'b1) $display("FAIL bp_valid cyc=%0d got=%b exp=1", cyc, out_valid); else pass_cnt++;
      chk_cnt++; if (out_data !== 32'(acc + 1)) $display("FAIL bp_data cyc=%0d got=%h exp=%h", cyc, out_data, 32'(acc + 1)); else pass_cnt++;
      chk_cnt++; if (in_mid_rd !== (acc > 0)) $display("FAIL bp_mid cyc=%0d got=%b exp=%b", cyc, in_mid_rd, (acc > 0)); else pass_cnt++;
      chk_cnt++; if (words_left !== 3'(6 - acc)) $display("FAIL bp_words_left cyc=%0d got=%0d exp=%0d", cyc, words_left, 6 - acc); else pass_cnt++;
      chk_cnt++; if (ehr_word_rd !== out_ready) $display("FAIL bp_word_rd cyc=%0d got=%b exp=%b", cyc, ehr_word_rd, out_ready); else pass_cnt++;
      if (ehr_word_rd === 1'b1) rd_cnt++;
      if (out_ready) begin
        $display("backpressure: word %0d data=%h accepted at cycle %0d", acc + 1, out_data, cyc);
        acc++;
      end
      cyc++;
    end
    chk_cnt++; if (acc !== 6) $display("FAIL bp_timeout accepted=%0d exp=6", acc); else pass_cnt++;
    chk_cnt++; if (rd_cnt !== 6) $display("FAIL bp_rd_count got=%0d exp=6", rd_cnt); else pass_cnt++;
    @(negedge rng_clk); out_ready = 1'b1; #1;
    chk_cnt++; if (ehr_rd_done !== 1'b1) $display("FAIL bp_done got=%b exp=1", ehr_rd_done); else pass_cnt++;
    chk_cnt++; if (in_mid_rd !== 1'b0) $display("FAIL bp_done_mid got=%b exp=0", in_mid_rd); else pass_cnt++;
    @(negedge rng_clk);
  endtask

  task automatic test_abort();
    @(negedge rng_clk); ehr_data = d_inc; ehr_valid_in = 1'b1; out_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge rng_clk); ehr_valid_in = 1'b0; #1;
      chk_cnt++; if (out_data !== 32'(k)) $display("FAIL abort_pre_data k=%0d got=%h exp=%h", k, out_data, 32'(k)); else pass_cnt++;
    end
    @(negedge rng_clk); rst_trng_logic = 1'b1; #1;
    chk_cnt++; if (out_data !== 32'd4) $display("FAIL abort_word4 got=%h exp=4", out_data); else pass_cnt++;
    chk_cnt++; if (ehr_word_rd !== 1'b0) $display("FAIL abort_word_rd_mask got=%b exp=0", ehr_word_rd); else pass_cnt++;
    $display("abort: rst_trng_logic asserted with word 4 pending");
    @(negedge rng_clk); rst_trng_logic = 1'b0; #1;
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL abort_idle got=%b exp=0", out_valid); else pass_cnt++;
    chk_cnt++; if (in_mid_rd !== 1'b0) $display("FAIL abort_mid got=%b exp=0", in_mid_rd); else pass_cnt++;
    chk_cnt++; if (words_left !== 3'd0) $display("FAIL abort_words_left got=%0d exp=0", words_left); else pass_cnt++;
    chk_cnt++; if (ehr_rd_done !== 1'b0) $display("FAIL abort_no_done got=%b exp=0", ehr_rd_done); else pass_cnt++;
    @(negedge rng_clk); #1;
    chk_cnt++; if (ehr_rd_done !== 1'b0) $display("FAIL abort_no_done2 got=%b exp=0", ehr_rd_done); else pass_cnt++;
    ehr_valid_in = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge rng_clk); ehr_valid_in = 1'b0; #1;
      chk_cnt++; if (out_data !== 32'(k)) $display("FAIL abort_restart_data k=%0d got=%h exp=%h", k, out_data, 32'(k)); else pass_cnt++;
      $display("abort: restarted word %0d data=%h", k, out_data);
    end
    @(negedge rng_clk); #1;
    chk_cnt++; if (ehr_rd_done !== 1'b1) $display("FAIL abort_restart_done got=%b exp=1", ehr_rd_done); else pass_cnt++;
    @(negedge rng_clk);
  endtask

  task automatic test_snapshot_isolation();
    @(negedge rng_clk); ehr_data = d_hund; ehr_valid_in = 1'b1; out_ready = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge rng_clk);
      ehr_valid_in = (k == 3);
      if (k == 3) ehr_data = '1;
      #1;
      chk_cnt++; if (out_data !== 32'h100 + 32'(k)) $display("FAIL iso_data k=%0d got=%h exp=%h", k, out_data, 32'h100 + 32'(k)); else pass_cnt++;
      $display("isolation: word %0d data=%h", k, out_data);
    end
    ehr_valid_in = 1'b0;
    @(negedge rng_clk); #1;
    chk_cnt++; if (ehr_rd_done !== 1'b1) $display("FAIL iso_done got=%b exp=1", ehr_rd_done); else pass_cnt++;
    @(negedge rng_clk); #1;
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL iso_ignored_valid got=%b exp=0", out_valid); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int ph;
    @(negedge rng_clk); ehr_data = d_inc; ehr_valid_in = 1'b1; out_ready = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge rng_clk);
      if (c == 15) ehr_valid_in = 1'b0;
      #1;
      ph = (c - 1) % 8;
      chk_cnt++; if (out_valid !== (ph < 6)) $display("FAIL b2b_valid c=%0d got=%b exp=%b", c, out_valid, (ph < 6)); else pass_cnt++;
      chk_cnt++; if (ehr_rd_done !== (ph == 6)) $display("FAIL b2b_done c=%0d got=%b exp=%b", c, ehr_rd_done, (ph == 6)); else pass_cnt++;
      if (ph < 6) begin
        chk_cnt++; if (out_data !== 32'(ph + 1)) $display("FAIL b2b_data c=%0d got=%h exp=%h", c, out_data, 32'(ph + 1)); else pass_cnt++;
      end
      $display("back_to_back: cycle %0d valid=%b data=%h done=%b", c, out_valid, out_data, ehr_rd_done);
    end
    @(negedge rng_clk); #1;
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL b2b_stop got=%b exp=0", out_valid); else pass_cnt++;
  endtask

`ifdef TRNG_EHR_ZEROIZE_EN
  task automatic test_zeroize();
    @(negedge rng_clk); ehr_data = d_inc; ehr_valid_in = 1'b1; out_ready = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge rng_clk); ehr_valid_in = 1'b0;
    end
    @(negedge rng_clk); #1;
    chk_cnt++; if (ehr_rd_done !== 1'b1) $display("FAIL zero_done got=%b exp=1", ehr_rd_done); else pass_cnt++;
    chk_cnt++; if (dut.shadow_q !== 192'h0) $display("FAIL zero_shadow got=%h exp=0", dut.shadow_q); else pass_cnt++;
    $display("zeroize: shadow after done=%h", dut.shadow_q);
    @(negedge rng_clk);
  endtask
`endif

  task automatic test_reset_mid_stream();
    @(negedge rng_clk); ehr_data = d_inc; ehr_valid_in = 1'b1; out_ready = 1'b0;
    @(negedge rng_clk); ehr_valid_in = 1'b0; out_ready = 1'b1;
    @(negedge rng_clk); #1;
    chk_cnt++; if (in_mid_rd !== 1'b1) $display("FAIL rstmid_pre_mid got=%b exp=1", in_mid_rd); else pass_cnt++;
    chk_cnt++; if (out_data !== 32'd2) $display("FAIL rstmid_pre_data got=%h exp=2", out_data); else pass_cnt++;
    rst_n = 1'b0; rst_trng_logic = 1'b1;
    @(negedge rng_clk); #1;
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL rstmid_valid got=%b exp=0", out_valid); else pass_cnt++;
    chk_cnt++; if (out_data !== 32'h0) $display("FAIL rstmid_data got=%h exp=0", out_data); else pass_cnt++;
    chk_cnt++; if (out_last !== 1'b0) $display("FAIL rstmid_last got=%b exp=0", out_last); else pass_cnt++;
    chk_cnt++; if (ehr_word_rd !== 1'b0) $display("FAIL rstmid_word_rd got=%b exp=0", ehr_word_rd); else pass_cnt++;
    chk_cnt++; if (ehr_rd_done !== 1'b0) $display("FAIL rstmid_done got=%b exp=0", ehr_rd_done); else pass_cnt++;
    chk_cnt++; if (in_mid_rd !== 1'b0) $display("FAIL rstmid_mid got=%b exp=0", in_mid_rd); else pass_cnt++;
    chk_cnt++; if (words_left !== 3'd0) $display("FAIL rstmid_words_left got=%0d exp=0", words_left); else pass_cnt++;
    $display("reset_mid_stream: outputs after rst_n edge valid=%b data=%h", out_valid, out_data);
    rst_n = 1'b1; rst_trng_logic = 1'b0;
    @(negedge rng_clk);
  endtask

  initial begin
    for (int k = 0; k < 6; k++) begin
      d_inc[k*32 +: 32]  = 32'(k + 1);
      d_hund[k*32 +: 32] = 32'h100 + 32'(k + 1);
    end
    test_reset();
    test_stream();
    test_backpressure();
    test_abort();
    test_snapshot_isolation();
    test_back_to_back();
`ifdef TRNG_EHR_ZEROIZE_EN
    test_zeroize();
`endif
    test_reset_mid_stream();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
